fft_frame_sequencer: RTL and testbench

Frame scheduler in front of `fft_power`: accepts a continuous stream of 32-bit float audio samples, buffers them in a ring buffer, and issues overlapping frames of `N` samples (advance `HOP` per frame) to `fft_power` over its valid/ready input. It runs one frame in flight at a time: it does not start the next frame until `fft_power` has delivered the `last` beat of the current spectrum. Software configures a frame count and starts the block from the AHB-side register file.

---
 rtl/mfcc_pkg.sv | 16 +
 rtl/ring_buf.sv | 25 ++
 rtl/fft_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC front-end (frame sequencer, FFT feed).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mfcc_pkg;
   localparam int SAMPLE_W   = 32;   // IEEE-754 single
   localparam int FFT_N      = 256;  // FFT length, samples per frame
   localparam int HOP_DFLT   = 128;  // default frame advance
   localparam int DEPTH_DFLT = 512;  // default ring-buffer depth

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_SEND,
      ST_WAIT
   } seq_state_t;
endpackage

// File: rtl/ring_buf.sv
// Sample ring buffer: DEPTH x SAMPLE_W register array, pointers live in the parent.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none here; the parent never writes into live samples.
// Ports: hclk; we/waddr/wdata write port; raddr/rdata read port.
import mfcc_pkg::*;

module ring_buf #(
   parameter int DEPTH = DEPTH_DFLT,
   localparam int AW  = $clog2(DEPTH)
) (
   input  logic                hclk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [SAMPLE_W-1:0] wdata,
   input  logic [AW-1:0]       raddr,
   output logic [SAMPLE_W-1:0] rdata
);
   logic [SAMPLE_W-1:0] mem [DEPTH];

   always_ff @(posedge hclk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fft_frame_sequencer.sv
// Buffers the audio sample stream and issues overlapping N-sample frames (advance HOP) to fft_power.
// Latency: first beat the cycle after the N-th sample is stored; one beat/cycle while f_ready is high.
// Backpressure: s_ready drops when the buffer is full; one frame in flight, next starts after spectrum p_last.
// Ports: start/num_frames/abort control; s_* sample input; f_* frame output; p_* fft_power output taps;
//        busy/done/frame_idx status.
import mfcc_pkg::*;

module fft_frame_sequencer #(
   parameter int N     = FFT_N,
   parameter int HOP   = HOP_DFLT,
   parameter int DEPTH = DEPTH_DFLT
) (
   input  logic                hclk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [15:0]         num_frames,
   input  logic                abort,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [SAMPLE_W-1:0] f_data,
   output logic                f_valid,
   input  logic                f_ready,
   input  logic                p_valid,
   input  logic                p_ready,
   input  logic                p_last,
   output logic                busy,
   output logic                done,
   output logic [15:0]         frame_idx
);
   localparam int AW = $clog2(DEPTH);
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   localparam logic [AW:0]   N_C     = (AW+1)'(N);
   localparam logic [AW:0]   HOP_C   = (AW+1)'(HOP);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] HOP_P   = AW'(HOP);   // modulo DEPTH
   localparam logic [KW-1:0] K_LAST  = KW'(N-1);

   seq_state_t state, state_nxt;

   logic [AW:0]           cnt;        // samples held from base onward
   logic [AW:0]           cnt_nxt;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         base;       // first sample of the current frame
   logic [AW-1:0]         rd_ptr;
   logic [KW-1:0]         k;          // beat within the frame
   logic [15:0]           cfg_frames;
   logic                  done_r;
   logic [SAMPLE_W-1:0]   rd_dat;

   logic wr, f_fire, p_fire, last_beat, final_frame;

   assign wr          = s_valid & s_ready;
   assign f_fire      = f_valid & f_ready;
   assign p_fire      = p_valid & p_ready & p_last;
   assign last_beat   = (state == ST_SEND) && f_fire && (k == K_LAST);
   // A write and a HOP release may land on the same edge.
   assign cnt_nxt     = cnt + {{AW{1'b0}}, wr} - (last_beat ? HOP_C : '0);
   assign final_frame = abort || ((cfg_frames != 16'd0) && (frame_idx == cfg_frames - 16'd1));

   ring_buf #(.DEPTH(DEPTH)) u_ring_buf (
      .hclk  (hclk),
      .we    (wr),
      .waddr (wr_ptr),
      .wdata (s_data),
      .raddr (rd_ptr),
      .rdata (rd_dat)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_FILL;
         // Looking at cnt_nxt lets the frame start the cycle right after its N-th sample lands.
         ST_FILL: begin
            if (abort)                 state_nxt = ST_IDLE;
            else if (cnt_nxt >= N_C)   state_nxt = ST_SEND;
         end
         ST_SEND: if (last_beat) state_nxt = ST_WAIT;
         ST_WAIT: if (p_fire)    state_nxt = final_frame ? ST_IDLE : ST_FILL;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   assign busy    = (state != ST_IDLE);
   assign s_ready = busy && (cnt < DEPTH_C);
   assign f_valid = (state == ST_SEND);
   assign f_data  = f_valid ? rd_dat : '0;
   assign done    = done_r;

   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         wr_ptr     <= '0;
         base       <= '0;
         rd_ptr     <= '0;
         k          <= '0;
         cfg_frames <= '0;
         frame_idx  <= '0;
         done_r     <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= 1'b0;
         cnt    <= cnt_nxt;
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  cfg_frames <= num_frames;
                  frame_idx  <= '0;
                  wr_ptr     <= '0;
                  base       <= '0;
                  cnt        <= '0;
               end
            end
            ST_FILL: begin
               if (state_nxt == ST_SEND) begin
                  rd_ptr <= base;
                  k      <= '0;
               end
            end
            ST_SEND: begin
               if (f_fire) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  k      <= k + 1'b1;
               end
               if (last_beat) base <= base + HOP_P;
            end
            ST_WAIT: begin
               if (p_fire) begin
                  if (final_frame) done_r    <= 1'b1;
                  else             frame_idx <= frame_idx + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: reference model of the frame stream plus directed scenarios.
// Latency: n/a.
// Backpressure: drives f_ready toggling and p_ready stalls.
module tb_fft_frame_sequencer;
   localparam int N = 256, HOP = 128, DEPTH = 512;

   logic        hclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_frames = '0;
   logic        abort = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] f_data;
   logic        f_valid;
   logic        f_ready = 1'b1;
   logic        p_valid = 1'b0;
   logic        p_ready = 1'b1;
   logic        p_last = 1'b0;
   logic        busy, done;
   logic [15:0] frame_idx;

   fft_frame_sequencer dut (
      .hclk(hclk), .rst_n(rst_n), .start(start), .num_frames(num_frames), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
      .p_valid(p_valid), .p_ready(p_ready), .p_last(p_last),
      .busy(busy), .done(done), .frame_idx(frame_idx)
   );

   always #5 hclk = ~hclk;

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (per run) ----------------
   logic [31:0] fed[$];     // samples accepted this run, in order
   logic [31:0] cap[$];     // frame beats delivered this run, in order
   int  m_acc = 0, m_beats = 0, m_deliv = 0, m_cfg = 0, m_cnt = 0, idx = 0, done_cnt = 0;
   bit  m_busy = 0, exp_done = 0, s_fire_n = 0, p_fire_n = 0, sim_seen = 0, full_seen = 0;

   // stimulus controls
   int          feed_left = 0;
   logic [31:0] feed_val = '0;
   bit          f_toggle = 0, p_ready_en = 1;

   // Checks current-cycle outputs against the model, then books the handshakes of the coming edge.
   always @(negedge hclk) begin
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_s_ready", s_ready, 0);
         chk("rst_f_valid", f_valid, 0);
         chk("rst_f_data", f_data, 0);
         chk("rst_done", done, 0);
         chk("rst_frame_idx", frame_idx, 0);
         m_busy = 0; exp_done = 0; s_fire_n = 0; p_fire_n = 0;
         m_acc = 0; m_beats = 0; m_deliv = 0;
      end else begin
         // Buffer occupancy: everything accepted minus HOP per completed frame.
         m_cnt = m_acc - HOP * (m_beats / N);
         chk("busy", busy, m_busy);
         chk("done", done, exp_done);
         chk("s_ready", s_ready, (m_busy && m_cnt < DEPTH) ? 1 : 0);
         if (m_busy) begin
            chk("cnt", dut.cnt, m_cnt);
            chk("frame_idx", frame_idx, m_deliv);
            if (m_cnt == DEPTH) full_seen = 1;
         end
         if (f_valid) begin
            // Beat b of frame j carries sample j*HOP + b of the run.
            idx = (m_beats / N) * HOP + (m_beats % N);
            if (idx < fed.size()) chk("f_data", f_data, fed[idx]);
            else                  chk("f_data_underrun", idx, fed.size());
         end else begin
            chk("f_data_idle", f_data, 0);
         end

         exp_done = 0;
         p_fire_n = p_valid && p_ready && p_last;
         if (p_fire_n && m_busy) begin
            if (abort || (m_cfg != 0 && m_deliv == m_cfg - 1)) begin
               m_busy = 0; exp_done = 1; done_cnt++;
            end else begin
               m_deliv++;
            end
         end
         if (start && !m_busy && !exp_done) begin
            m_busy = 1; m_cfg = num_frames; m_acc = 0; m_beats = 0; m_deliv = 0;
            fed.delete(); cap.delete();
         end
         s_fire_n = s_valid && s_ready;
         if (s_fire_n) begin fed.push_back(s_data); m_acc++; end
         if (f_valid && f_ready) begin
            cap.push_back(f_data);
            if ((m_beats % N) == N - 1 && s_fire_n) sim_seen = 1;
            m_beats++;
         end
      end
   end

   // Sample source, FFT-input readiness and a one-beat-per-frame spectrum responder.
   initial begin
      forever begin
         @(posedge hclk); #1;
         if (s_fire_n) begin feed_val = feed_val + 1; feed_left = feed_left - 1; end
         s_valid = (feed_left > 0);
         s_data  = feed_val;
         f_ready = f_toggle ? ~f_ready : 1'b1;
         p_ready = p_ready_en;
         if (!rst_n || p_fire_n) begin
            p_valid = 0; p_last = 0;
         end else if (!p_valid && m_busy && m_deliv < m_beats / N) begin
            p_valid = 1; p_last = 1;
         end
      end
   end

   task automatic pulse_start(input int n);
      @(posedge hclk); #2;
      num_frames = 16'(n); start = 1;
      @(posedge hclk); #2;
      start = 0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0 = done_cnt;
      int c = 0;
      while (done_cnt == d0 && c < budget) begin @(posedge hclk); c++; end
      chk(name, (done_cnt != d0) ? 1 : 0, 1);
      repeat (3) @(posedge hclk);
   endtask

   task automatic wait_beats(input string name, input int n, input int budget);
      int c = 0;
      while (m_beats < n && c < budget) begin @(posedge hclk); c++; end
      chk(name, (m_beats >= n) ? 1 : 0, 1);
   endtask

   task automatic load_feed(input logic [31:0] v, input int n);
      @(posedge hclk); #2;
      feed_val = v; feed_left = n;
   endtask

   task automatic basic_run(input string tag);
      int d0;
      d0 = done_cnt;
      load_feed(32'd0, 256);
      pulse_start(1);
      wait_done({tag, "_done_seen"}, 2000);
      chk({tag, "_beats"}, cap.size(), 256);
      chk({tag, "_first"}, cap[0], 0);
      chk({tag, "_mid"}, cap[100], 100);
      chk({tag, "_last"}, cap[255], 255);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge hclk);
      #2 rst_n = 1;

      // Basic: one frame of 0..255
      basic_run("basic");

      // Overlap: three frames at 0,128,256; input keeps flowing through the last beat
      load_feed(32'd0, 600);
      pulse_start(3);
      wait_done("ovl_done_seen", 5000);
      chk("ovl_beats", cap.size(), 768);
      chk("ovl_f1_first", cap[256], 128);
      chk("ovl_f2_first", cap[512], 256);
      chk("ovl_f2_last", cap[767], 511);
      chk("ovl_sim_write_release", sim_seen, 1);

      // Backpressure: f_ready toggling, spectrum stalled for 100 cycles
      load_feed(32'd1000, 700);
      f_toggle = 1; p_ready_en = 0;
      pulse_start(3);
      wait_beats("bp_frame0", 256, 3000);
      repeat (100) @(posedge hclk);
      #2 p_ready_en = 1;
      wait_done("bp_done_seen", 10000);
      f_toggle = 0;
      chk("bp_full_seen", full_seen, 1);
      chk("bp_beats", cap.size(), 768);
      chk("bp_f1_first", cap[256], 1128);
      chk("bp_f2_last", cap[767], 1511);

      // Wrap: free-running, abort during frame 5 SEND
      load_feed(32'h5000, 2048);
      pulse_start(0);
      wait_beats("wrap_frame5", 5 * 256 + 10, 20000);
      #2 abort = 1;
      wait_done("wrap_done_seen", 5000);
      #2 abort = 0;
      chk("wrap_beats", cap.size(), 1536);
      chk("wrap_f4_first", cap[1024], 32'h5000 + 512);
      chk("wrap_f5_first", cap[1280], 32'h5000 + 640);
      chk("wrap_f5_last", cap[1535], 32'h5000 + 895);

      // Reset mid-SEND at beat 100, then rerun Basic
      load_feed(32'd0, 256);
      pulse_start(1);
      wait_beats("rst_reach_beat100", 100, 2000);
      #2 rst_n = 0;
      @(posedge hclk); #2 rst_n = 1;
      feed_left = 0;
      basic_run("rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
